// File: rtl/key_recorder.sv
// Records debounced key-board playing as (note, duration) entries.
// A synchronous read port serves the auto-play path.
module key_recorder #(
  parameter int TICK_CYCLES    = 1000000,
  parameter int DEBOUNCE_TICKS = 2,
  parameter int DEPTH          = 256,
  parameter int AW             = 8,
  parameter int DUR_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rec_en,
  input  logic [7:0]       key_board_in,
  input  logic [AW-1:0]    rd_addr,
  output logic [3:0]       rd_note,
  output logic [DUR_W-1:0] rd_dur,
  output logic [AW:0]      length,
  output logic             busy,
  output logic             done,
  output logic             full
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int RW = $clog2(DEBOUNCE_TICKS + 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ARMED = 3'd1;
  localparam logic [2:0] REC   = 3'd2;
  localparam logic [2:0] FLUSH = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [DUR_W-1:0] DUR_MAX = '1;
  localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

  logic [7:0]       sync1, sync2, samp, acc;
  logic [RW-1:0]    run, next_run;
  logic [CW-1:0]    tcnt;
  logic             tick;
  logic [3:0]       note, cur;
  logic [DUR_W-1:0] dur;
  logic [2:0]       state;
  logic             rec_q, rise, we;

  logic [3:0]       mem_note [DEPTH];
  logic [DUR_W-1:0] mem_dur  [DEPTH];

  assign tick = (tcnt == CW'(TICK_CYCLES - 1));
  assign rise = rec_en & ~rec_q;
  assign busy = (state == ARMED) | (state == REC) | (state == FLUSH);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      tcnt  <= '0;
      rec_q <= 1'b0;
    end else begin
      sync1 <= key_board_in;
      sync2 <= sync1;
      tcnt  <= tick ? '0 : tcnt + 1'b1;
      rec_q <= rec_en;
    end
  end

  // run = consecutive equal tick samples, saturating at DEBOUNCE_TICKS
  always_comb begin
    next_run = run;
    if (sync2 != samp)
      next_run = RW'(1);
    else if (run < RW'(DEBOUNCE_TICKS))
      next_run = run + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp <= '0;
      run  <= '0;
      acc  <= '0;
    end else if (tick) begin
      samp <= sync2;
      run  <= next_run;
      if (next_run >= RW'(DEBOUNCE_TICKS))
        acc <= sync2;
    end
  end

  always_comb begin
    note = '0;
    for (int i = 7; i >= 0; i--)
      if (acc[i]) note = 4'(i + 1);
  end

  // Every write stores the current (cur, dur) pair; saturation has dur = MAX.
  always_comb begin
    we = 1'b0;
    unique case (1'b1)
      state == REC:
        we = rec_en & tick & ((note != cur) | (dur == DUR_MAX));
      state == FLUSH:
        we = (cur != 4'd0);
      default: we = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cur    <= '0;
      dur    <= '0;
      length <= '0;
      full   <= 1'b0;
    end else begin
      if (we)
        length <= length + 1'b1;
      unique case (state)
        IDLE, DONE: begin
          if (rise) begin
            length <= '0;
            full   <= 1'b0;
            state  <= ARMED;
          end
        end
        ARMED: begin
          if (!rec_en)
            state <= DONE;
          else if (tick && note != 4'd0) begin
            cur   <= note;
            dur   <= DUR_W'(1);
            state <= REC;
          end
        end
        REC: begin
          if (!rec_en)
            state <= FLUSH;
          else if (tick) begin
            if (we) begin
              cur <= note;
              dur <= DUR_W'(1);
              if (length == LAST) begin
                full  <= 1'b1;
                state <= DONE;
              end
            end else begin
              dur <= dur + 1'b1;
            end
          end
        end
        FLUSH: begin
          if (we && length == LAST)
            full <= 1'b1;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem_note[length[AW-1:0]] <= cur;
      mem_dur[length[AW-1:0]]  <= dur;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_note <= '0;
      rd_dur  <= '0;
    end else begin
      rd_note <= mem_note[rd_addr];
      rd_dur  <= mem_dur[rd_addr];
    end
  end

endmodule

// File: tb/tb_key_recorder.sv
// Directed bench for key_recorder with small parameters.
// Tick = 4 clk; all key changes spaced in whole ticks.
module tb_key_recorder;

  logic       clk = 1'b0;
  logic       rst;
  logic       rec_en;
  logic [7:0] key_board_in;
  logic [1:0] rd_addr;
  logic [3:0] rd_note;
  logic [3:0] rd_dur;
  logic [2:0] length;
  logic       busy, done, full;

  int total = 0;
  int passed = 0;

  key_recorder #(
    .TICK_CYCLES(4), .DEBOUNCE_TICKS(2),
    .DEPTH(4), .AW(2), .DUR_W(4)
  ) dut (
    .clk(clk), .rst(rst), .rec_en(rec_en),
    .key_board_in(key_board_in), .rd_addr(rd_addr),
    .rd_note(rd_note), .rd_dur(rd_dur),
    .length(length), .busy(busy), .done(done), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         test;
    logic [1:0] addr;
    logic [3:0] note;
    logic [3:0] dur;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  task automatic hold(input logic [7:0] k, input int n);
    key_board_in = k;
    repeat (4 * n) @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] a,
                    output logic [3:0] n, output logic [3:0] d);
    @(negedge clk) rd_addr = a;
    @(negedge clk);
    n = rd_note;
    d = rd_dur;
  endtask

  task automatic check_entries(input int t);
    logic [3:0] n, d;
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].test == t) begin
        rd(vecs[i].addr, n, d);
        chk($sformatf("t%0d note[%0d]", t, vecs[i].addr), n, vecs[i].note);
        chk($sformatf("t%0d dur[%0d]", t, vecs[i].addr), d, vecs[i].dur);
      end
    end
  endtask

  task automatic status(input string t, input int l, input int dn,
                        input int fl, input int bz);
    chk({t, " length"}, length, l);
    chk({t, " done"}, done, dn);
    chk({t, " full"}, full, fl);
    chk({t, " busy"}, busy, bz);
  endtask

  task automatic start_take();
    @(negedge clk) rec_en = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic end_take();
    hold(8'h00, 4);
    rec_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [3:0] n, d;
    vecs[0] = '{1, 2'd0, 4'd3, 4'd5};
    vecs[1] = '{1, 2'd1, 4'd0, 4'd3};
    vecs[2] = '{1, 2'd2, 4'd1, 4'd2};
    vecs[3] = '{2, 2'd0, 4'd8, 4'd15};
    vecs[4] = '{2, 2'd1, 4'd8, 4'd5};
    vecs[5] = '{3, 2'd0, 4'd2, 4'd7};
    vecs[6] = '{4, 2'd0, 4'd1, 4'd2};
    vecs[7] = '{4, 2'd1, 4'd2, 4'd2};
    vecs[8] = '{4, 2'd2, 4'd1, 4'd2};
    vecs[9] = '{4, 2'd3, 4'd2, 4'd2};

    rst = 1'b1;
    rec_en = 1'b0;
    key_board_in = 8'h00;
    rd_addr = 2'd0;
    repeat (3) @(negedge clk);
    status("reset", 0, 0, 0, 0);
    chk("reset rd_note", rd_note, 0);
    chk("reset rd_dur", rd_dur, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    status("idle", 0, 0, 0, 0);

    // 1: basic take
    start_take();
    chk("t1 busy armed", busy, 1);
    hold(8'h04, 5);
    hold(8'h00, 3);
    hold(8'h01, 2);
    end_take();
    status("t1", 3, 1, 0, 0);
    check_entries(1);

    // read latency: new address visible exactly one clk later
    @(negedge clk) rd_addr = 2'd0;
    @(negedge clk) rd_addr = 2'd1;
    #1;
    chk("lat before note", rd_note, 3);
    chk("lat before dur", rd_dur, 5);
    @(posedge clk);
    #1;
    chk("lat after note", rd_note, 0);
    chk("lat after dur", rd_dur, 3);

    // 2: saturation splits a long note
    start_take();
    hold(8'h80, 20);
    end_take();
    status("t2", 2, 1, 0, 0);
    check_entries(2);

    // 3: lowest key wins, single-tick glitches rejected
    start_take();
    hold(8'h06, 4);
    hold(8'h02, 1);
    hold(8'h00, 1);
    hold(8'h02, 1);
    end_take();
    status("t3", 1, 1, 0, 0);
    check_entries(3);

    // 4: buffer fills while rec_en still high
    start_take();
    for (int i = 0; i < 6; i++)
      hold(i % 2 == 0 ? 8'h01 : 8'h02, 2);
    hold(8'h04, 3);
    hold(8'h00, 3);
    status("t4", 4, 1, 1, 0);
    check_entries(4);
    @(negedge clk) rec_en = 1'b0;
    repeat (3) @(negedge clk);
    status("t4 after drop", 4, 1, 1, 0);

    // 6: empty take
    start_take();
    repeat (3) @(negedge clk);
    rec_en = 1'b0;
    repeat (3) @(negedge clk);
    status("t6", 0, 1, 0, 0);

    // 5: reset mid-take
    @(negedge clk) rd_addr = 2'd0;
    start_take();
    hold(8'h08, 5);
    chk("t5 busy rec", busy, 1);
    rst = 1'b1;
    rec_en = 1'b0;
    key_board_in = 8'h00;
    #1;
    status("t5 rst", 0, 0, 0, 0);
    chk("t5 rst rd_note", rd_note, 0);
    chk("t5 rst rd_dur", rd_dur, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    start_take();
    hold(8'h08, 3);
    end_take();
    status("t5 retake", 1, 1, 0, 0);
    rd(2'd0, n, d);
    chk("t5 note[0]", n, 4);
    chk("t5 dur[0]", d, 3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
